calc_seq_cu: RTL and testbench

//  Parametrised calculator control unit. Accumulates decimal digit entry into two WIDTH-bit operands and runs the

---
 rtl/calc_pkg.sv | 35 +++
 rtl/calc_slice_alu.sv | 44 ++++
 rtl/calc_seq_cu.sv | 248 ++++++++++++++++++++++++
 tb/tb_calc_seq_cu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state encoding and slice-count helpers for the sequential calculator.
package calc_pkg;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_CMP   = 3'd5;
  localparam logic [2:0] OP_PASSB = 3'd6;
  localparam logic [2:0] OP_NOTA  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENT_A = 3'd1,
    ST_OPW   = 3'd2,
    ST_ENT_B = 3'd3,
    ST_EXEC  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic int nslice(input int width, input int slice_w);
    return width / slice_w;
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // SUB and CMP both run as A + ~B + 1 through the adder.
  function automatic logic op_uses_ci(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/calc_slice_alu.sv
// Combinational SLICE_W-bit ALU slice; the control unit feeds it one operand slice per tick.
module calc_slice_alu
  import calc_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic [2:0]         op_i,
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               ci_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               co_o,
  output logic               zero_o
);

  logic [SLICE_W:0] sum;

  always_comb begin
    sum  = '0;
    s_o  = '0;
    co_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        sum  = {1'b0, a_i} + {1'b0, b_i} + (SLICE_W+1)'(ci_i);
        s_o  = sum[SLICE_W-1:0];
        co_o = sum[SLICE_W];
      end
      OP_SUB, OP_CMP: begin
        sum  = {1'b0, a_i} + {1'b0, ~b_i} + (SLICE_W+1)'(ci_i);
        s_o  = sum[SLICE_W-1:0];
        co_o = sum[SLICE_W];
      end
      OP_AND:   s_o = a_i & b_i;
      OP_OR:    s_o = a_i | b_i;
      OP_XOR:   s_o = a_i ^ b_i;
      OP_PASSB: s_o = b_i;
      OP_NOTA:  s_o = ~a_i;
      default:  s_o = '0;
    endcase
  end

  assign zero_o = (s_o == '0);

endmodule

// File: rtl/calc_seq_cu.sv
// Calculator control unit: decimal entry of two operands, slice-serial execution, chained operators.
// Define CALC_SAT_EN to clamp ADD overflow to all-ones and SUB underflow to zero instead of wrapping.
module calc_seq_cu
  import calc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [3:0]       num,
  input  logic             num_pressed,
  input  logic [2:0]       opt,
  input  logic             opt_pressed,
  input  logic             submit,
  input  logic             control,
  output logic [WIDTH-1:0] disp_value,
  output logic             cmp_sign,
  output logic             zero,
  output logic             carry,
  output logic             busy,
  output logic             complete
);

  localparam int NSLICE = nslice(WIDTH, SLICE_W);
  localparam int IDX_W  = idx_bits(NSLICE);
  localparam int EW     = WIDTH + 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, acc_q, acc_d;
  logic [2:0]       op_q, op_d, nop_q, nop_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic chain_q, chain_d, cy_q, cy_d, zacc_q, zacc_d;
  logic zero_q, zero_d, carry_q, carry_d, cmp_q, cmp_d, hold_q, hold_d;

  // Digit accumulation: one extra nibble of headroom catches overflow of entry*10+num.
  logic          dig_ok, a_fit, b_fit;
  logic [EW-1:0] a_ext, b_ext;

  assign dig_ok = (num <= 4'd9);
  assign a_ext  = EW'(a_q) * EW'(4'd10) + EW'(num);
  assign b_ext  = EW'(b_q) * EW'(4'd10) + EW'(num);
  assign a_fit  = dig_ok && (a_ext[EW-1:WIDTH] == '0);
  assign b_fit  = dig_ok && (b_ext[EW-1:WIDTH] == '0);

  logic [SLICE_W-1:0] sa, sb, ss;
  logic               sco, sz, last;
  logic [WIDTH-1:0]   slice_word, fres;
  logic               fz, fcarry;

  assign sa   = SLICE_W'(a_q >> (SLICE_W * int'(idx_q)));
  assign sb   = SLICE_W'(b_q >> (SLICE_W * int'(idx_q)));
  assign last = (idx_q == LAST_IDX);

  calc_slice_alu #(.SLICE_W(SLICE_W)) u_alu (
    .op_i   (op_q),
    .a_i    (sa),
    .b_i    (sb),
    .ci_i   (cy_q),
    .s_o    (ss),
    .co_o   (sco),
    .zero_o (sz)
  );

  // Slices shift in from the top so the first (LSB) slice lands at bit 0 after NSLICE ticks.
  assign slice_word = (acc_q >> SLICE_W) | (WIDTH'(ss) << (WIDTH - SLICE_W));

  always_comb begin
    fres   = slice_word;
    fz     = zacc_q & sz;
    fcarry = 1'b0;
    if (op_q == OP_ADD) begin
      fcarry = sco;
    end else if (op_uses_ci(op_q)) begin
      fcarry = ~sco;
    end
`ifdef CALC_SAT_EN
    if ((op_q == OP_ADD) && sco) begin
      fres = '1;
      fz   = 1'b0;
    end else if ((op_q == OP_SUB) && !sco) begin
      fres = '0;
      fz   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (num_pressed) begin
            if (dig_ok) state_d = ST_ENT_A;
          end else if (opt_pressed) begin
            state_d = ST_OPW;
          end
        end
        ST_ENT_A: if (!num_pressed && opt_pressed) state_d = ST_OPW;
        ST_OPW: begin
          if (num_pressed && dig_ok) state_d = ST_ENT_B;
        end
        ST_ENT_B: if (!num_pressed && (opt_pressed || submit)) state_d = ST_EXEC;
        ST_EXEC:  if (last) state_d = chain_q ? ST_OPW : ST_DONE;
        ST_DONE:  if (!submit) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q == ST_EXEC);
    complete   = (state_q == ST_DONE) || ((state_q == ST_IDLE) && hold_q);
    zero       = 1'b0;
    carry      = 1'b0;
    cmp_sign   = cmp_q;
    disp_value = a_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        disp_value = res_q;
        zero       = zero_q;
        carry      = carry_q;
      end
      ST_ENT_B, ST_EXEC: disp_value = b_q;
      default:           disp_value = a_q;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    op_d    = op_q;
    nop_d   = nop_q;
    idx_d   = idx_q;
    chain_d = chain_q;
    cy_d    = cy_q;
    zacc_d  = zacc_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    cmp_d   = cmp_q;
    hold_d  = hold_q;
    if (tick) begin
      // complete survives into IDLE only while control stays high; once dropped it stays clear.
      hold_d = (state_q == ST_DONE) || ((state_q == ST_IDLE) && hold_q && control);
      case (state_q)
        ST_IDLE: begin
          if (num_pressed) begin
            if (dig_ok) a_d = WIDTH'(num);
          end else if (opt_pressed) begin
            op_d = opt;
            a_d  = res_q;
          end
        end
        ST_ENT_A: begin
          if (num_pressed) begin
            if (a_fit) a_d = a_ext[WIDTH-1:0];
          end else if (opt_pressed) begin
            op_d = opt;
          end
        end
        ST_OPW: begin
          if (num_pressed) begin
            if (dig_ok) b_d = WIDTH'(num);
          end else if (opt_pressed) begin
            op_d = opt;
          end
        end
        ST_ENT_B: begin
          if (num_pressed) begin
            if (b_fit) b_d = b_ext[WIDTH-1:0];
          end else if (opt_pressed || submit) begin
            chain_d = opt_pressed;
            if (opt_pressed) nop_d = opt;
            idx_d  = '0;
            acc_d  = '0;
            zacc_d = 1'b1;
            cy_d   = op_uses_ci(op_q);
          end
        end
        ST_EXEC: begin
          acc_d  = slice_word;
          cy_d   = sco;
          zacc_d = zacc_q & sz;
          idx_d  = idx_q + IDX_W'(1);
          if (last) begin
            res_d   = (op_q == OP_CMP) ? res_q : fres;
            zero_d  = fz;
            carry_d = fcarry;
            cmp_d   = (op_q == OP_CMP) && !sco;
            if (chain_q) begin
              op_d = nop_q;
              a_d  = res_d;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      op_q    <= OP_ADD;
      nop_q   <= OP_ADD;
      idx_q   <= '0;
      chain_q <= 1'b0;
      cy_q    <= 1'b0;
      zacc_q  <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      cmp_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      nop_q   <= nop_d;
      idx_q   <= idx_d;
      chain_q <= chain_d;
      cy_q    <= cy_d;
      zacc_q  <= zacc_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      cmp_q   <= cmp_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_calc_seq_cu.sv
// Randomized and directed bench for calc_seq_cu against a whole-word behavioural calculator model.
module tb_calc_seq_cu;

  localparam int     WIDTH   = 16;
  localparam int     SLICE_W = 8;
  localparam int     NSL     = WIDTH / SLICE_W;
  localparam longint MAXV    = (64'd1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0, tick = 1'b0, num_pressed = 1'b0, opt_pressed = 1'b0;
  logic             submit = 1'b0, control = 1'b0;
  logic [3:0]       num = '0;
  logic [2:0]       opt = '0;
  logic [WIDTH-1:0] disp_value;
  logic             cmp_sign, zero, carry, busy, complete;

  calc_seq_cu #(.WIDTH(WIDTH), .SLICE_W(SLICE_W)) dut (
    .clk(clk), .reset(reset), .tick(tick), .num(num), .num_pressed(num_pressed),
    .opt(opt), .opt_pressed(opt_pressed), .submit(submit), .control(control),
    .disp_value(disp_value), .cmp_sign(cmp_sign), .zero(zero), .carry(carry),
    .busy(busy), .complete(complete)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Behavioural model: phases of a pocket calculator, arithmetic done on whole words.
  typedef enum {M_IDLE, M_ENT_A, M_OPW, M_ENT_B, M_EXEC, M_DONE} mst_t;
  mst_t   m_st = M_IDLE;
  longint m_a = 0, m_b = 0, m_res = 0;
  int     m_op = 0, m_nop = 0, m_left = 0;
  bit     m_chain = 0, m_z = 0, m_c = 0, m_cs = 0, m_hold = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint accum(input longint x, input int d);
    if (d <= 9 && (x * 10 + d) <= MAXV) return x * 10 + d;
    return x;
  endfunction

  task automatic calc(input int op, input longint a, input longint b, output longint r, output bit c);
    c = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > MAXV); end
      1, 5: begin r = a - b; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      6: r = b;
      default: r = ~a;
    endcase
    r = r & MAXV;
  endtask

  task automatic model_edge();
    longint r;
    bit     c;
    if (!reset) begin
      m_st = M_IDLE; m_a = 0; m_b = 0; m_res = 0; m_op = 0; m_nop = 0; m_left = 0;
      m_chain = 0; m_z = 0; m_c = 0; m_cs = 0; m_hold = 0;
      return;
    end
    if (!tick) return;
    m_hold = (m_st == M_DONE) || (m_st == M_IDLE && m_hold && control);
    case (m_st)
      M_IDLE:
        if (num_pressed) begin
          if (num <= 9) begin m_a = num; m_st = M_ENT_A; end
        end else if (opt_pressed) begin
          m_op = opt; m_a = m_res; m_st = M_OPW;
        end
      M_ENT_A:
        if (num_pressed) m_a = accum(m_a, num);
        else if (opt_pressed) begin m_op = opt; m_st = M_OPW; end
      M_OPW:
        if (num_pressed) begin
          if (num <= 9) begin m_b = num; m_st = M_ENT_B; end
        end else if (opt_pressed) m_op = opt;
      M_ENT_B:
        if (num_pressed) m_b = accum(m_b, num);
        else if (opt_pressed) begin m_chain = 1; m_nop = opt; m_left = NSL; m_st = M_EXEC; end
        else if (submit) begin m_chain = 0; m_left = NSL; m_st = M_EXEC; end
      M_EXEC: begin
        m_left--;
        if (m_left == 0) begin
          calc(m_op, m_a, m_b, r, c);
          m_z = (r == 0); m_c = c; m_cs = (m_op == 5) ? c : 1'b0;
          if (m_op != 5) m_res = r;
          if (m_chain) begin m_op = m_nop; m_a = m_res; m_st = M_OPW; end
          else m_st = M_DONE;
        end
      end
      default: if (!submit) m_st = M_IDLE;
    endcase
  endtask

  function automatic longint exp_disp();
    if (m_st == M_IDLE || m_st == M_DONE) return m_res;
    if (m_st == M_ENT_B || m_st == M_EXEC) return m_b;
    return m_a;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit shown = (m_st == M_IDLE || m_st == M_DONE);
      chk("disp_value", disp_value, exp_disp());
      chk("zero", zero, shown & m_z);
      chk("carry", carry, shown & m_c);
      chk("cmp_sign", cmp_sign, m_cs);
      chk("busy", busy, m_st == M_EXEC);
      chk("complete", complete, (m_st == M_DONE) || (m_st == M_IDLE && m_hold));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // One ticked strobe, then a non-ticked cycle carrying a stray strobe that must be ignored.
  task automatic press(input bit np, input int n, input bit opp, input int o);
    tick = 1; num_pressed = np; num = 4'(n); opt_pressed = opp; opt = 3'(o);
    cyc();
    tick = 0; opt_pressed = 0; num_pressed = 1;
    cyc();
    num_pressed = 0;
  endtask

  task automatic dig(input int d);
    press(1, d, 0, 0);
  endtask

  task automatic op(input int o);
    press(0, 0, 1, o);
  endtask

  task automatic enter(input longint v);
    string s;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) dig(int'(s[i]) - 48);
  endtask

  task automatic exec_submit();
    submit = 1; tick = 1;
    repeat (NSL + 1) cyc();
    tick = 0;
  endtask

  task automatic release_sub();
    submit = 0; tick = 1;
    cyc();
    tick = 0;
  endtask

  initial begin
    reset = 0;
    cyc(); cyc();
    chk("rst_disp", disp_value, 0);
    chk("rst_flags", {cmp_sign, zero, carry, busy, complete}, 0);
    reset = 1;
    chk_en = 1;
    cyc();

    enter(123); op(0); enter(45);
    submit = 1; tick = 1; cyc();
    chk("exec_busy", busy, 1);
    cyc(); cyc(); tick = 0;
    chk("add168_disp", disp_value, 168);
    chk("add168_flags", {zero, carry, complete}, 3'b001);
    release_sub();
    chk("idle_hold_first", complete, 1);
    tick = 1; cyc(); tick = 0;
    chk("idle_clear", complete, 0);

    enter(255); op(0); enter(1); exec_submit();
    chk("add256_disp", disp_value, 256);
    chk("add256_carry", carry, 0);
    release_sub();

    enter(65535); op(0); enter(1); exec_submit();
    chk("wrap_disp", disp_value, 0);
    chk("wrap_flags", {zero, carry}, 2'b11);
    release_sub();

    enter(5); op(5); enter(9); exec_submit();
    chk("cmp59_sign", cmp_sign, 1);
    chk("cmp59_disp", disp_value, 0);
    release_sub();
    enter(9); op(5); enter(5); exec_submit();
    chk("cmp95_sign", cmp_sign, 0);
    release_sub();

    enter(10); op(0); enter(5); op(1);
    tick = 1; repeat (NSL) cyc(); tick = 0;
    chk("chain_mid_disp", disp_value, 15);
    chk("chain_mid_complete", complete, 0);
    enter(3); exec_submit();
    chk("chain_final", disp_value, 12);
    chk("chain_complete", complete, 1);
    release_sub();

    control = 1;
    enter(7); op(6); enter(4); exec_submit();
    chk("passb_disp", disp_value, 4);
    release_sub();
    tick = 1; repeat (3) cyc();
    chk("ctl_hold", complete, 1);
    control = 0; cyc(); tick = 0;
    chk("ctl_drop", complete, 0);

    dig(6); dig(5); dig(5); dig(3); dig(6);
    chk("entry_cap", disp_value, 6553);
    op(0); enter(2);
    submit = 1; tick = 1; cyc(); cyc();
    reset = 0; cyc();
    chk("abort_disp", disp_value, 0);
    chk("abort_flags", {busy, complete, zero, carry}, 0);
    reset = 1; submit = 0; tick = 0; cyc();

    for (int i = 0; i < 4000; i++) begin
      tick        = ($urandom % 4) != 0;
      num_pressed = ($urandom % 4) == 0;
      num         = 4'($urandom % 12);
      opt_pressed = ($urandom % 6) == 0;
      opt         = 3'($urandom % 8);
      if ($urandom % 5 == 0) submit = ~submit;
      if ($urandom % 50 == 0) control = ~control;
      reset = ($urandom % 300) != 0;
      cyc();
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
